// File: rtl/service_4.sv
// Alarm-clock mission service: arm, ring on time match, then the user
// copies NUM_MISSIONS random LED patterns onto the switches to finish.
module service_4 #(
  parameter int          NUM_MISSIONS = 3,
  parameter logic [9:0]  LFSR_SEED    = 10'b1011001110
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SPDT4,
  input  logic [9:0]  SPDTs,
  input  logic        push_m,
  input  logic [15:0] current,
  input  logic [15:0] alarm,
  output logic [2:0]  alarm_state,
  output logic [15:0] count_state,
  output logic [9:0]  SPDT_LED,
  output logic        finish4
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b100
  } state_t;

  state_t      state, state_n;
  logic [15:0] count, count_n;
  logic [9:0]  led, led_n;
  logic        fin, fin_n;
  logic [9:0]  lfsr;
  logic        push_q;

  logic        press;
  logic [9:0]  rot;
  logic [9:0]  load;

  assign press = push_m & ~push_q;
  assign rot   = {lfsr[8:0], lfsr[9]};

  // New pattern must always differ from what is currently shown.
  always_comb begin
    load = lfsr;
    if (lfsr == led) begin
      load = rot;
      if (rot == led)
        load = 10'h155;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    led_n   = led;
    fin_n   = fin;
    if (!SPDT4) begin
      state_n = S0;
      count_n = '0;
      led_n   = '0;
      fin_n   = 1'b0;
    end else begin
      unique case (state)
        S0: begin
          led_n = '0;
          if (!fin) begin
            state_n = S1;
            count_n = '0;
          end
        end
        S1: begin
          led_n = '0;
          if (current == alarm) begin
            state_n = S2;
            led_n   = 10'h3FF;
          end
        end
        S2: begin
          led_n = 10'h3FF;
          if (press) begin
            state_n = S3;
            led_n   = load;
          end
        end
        S3: begin
          if (SPDTs == led) begin
            count_n = count + 16'd1;
            if (count_n == 16'(NUM_MISSIONS)) begin
              state_n = S0;
              fin_n   = 1'b1;
              led_n   = '0;
            end else begin
              led_n = load;
            end
          end
        end
        default: state_n = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S0;
      count  <= '0;
      led    <= '0;
      fin    <= 1'b0;
      lfsr   <= LFSR_SEED;
      push_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      led    <= led_n;
      fin    <= fin_n;
      lfsr   <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      push_q <= push_m;
    end
  end

  assign alarm_state = state;
  assign count_state = count;
  assign SPDT_LED    = led;
  assign finish4     = fin;

endmodule

// File: tb/tb_service_4.sv
// Directed bench for service_4; tracks the pattern LFSR and the
// expected LED value independently of the design.
module tb_service_4;

  localparam logic [9:0] SEED = 10'b1011001110;

  logic        clk = 1'b0;
  logic        resetn;
  logic        SPDT4;
  logic [9:0]  SPDTs;
  logic        push_m;
  logic [15:0] current;
  logic [15:0] alarm;
  logic [2:0]  alarm_state;
  logic [15:0] count_state;
  logic [9:0]  SPDT_LED;
  logic        finish4;

  int errors = 0;
  int checks = 0;

  logic [9:0] m_lfsr;
  logic [9:0] exp_led;
  logic [9:0] prev_led;

  service_4 dut (
    .clk         (clk),
    .resetn      (resetn),
    .SPDT4       (SPDT4),
    .SPDTs       (SPDTs),
    .push_m      (push_m),
    .current     (current),
    .alarm       (alarm),
    .alarm_state (alarm_state),
    .count_state (count_state),
    .SPDT_LED    (SPDT_LED),
    .finish4     (finish4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!resetn) m_lfsr <= SEED;
    else         m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic logic [9:0] load_val(logic [9:0] l, logic [9:0] shown);
    logic [9:0] r;
    r = {l[8:0], l[9]};
    if (l != shown) return l;
    if (r != shown) return r;
    return 10'h155;
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn  = 1'b0;
    SPDT4   = 1'b0;
    SPDTs   = '0;
    push_m  = 1'b0;
    current = '0;
    alarm   = 16'd10;
    @(negedge clk);
    tick();
    tick();
    check("rst_state", 16'(alarm_state), 16'h0);
    check("rst_count", count_state, 16'h0);
    check("rst_led", 16'(SPDT_LED), 16'h0);
    check("rst_fin", 16'(finish4), 16'h0);

    resetn = 1'b1;
    SPDT4  = 1'b1;
    tick();
    check("arm_state", 16'(alarm_state), 16'h1);
    check("arm_led", 16'(SPDT_LED), 16'h0);

    for (int c = 0; c <= 20; c++) begin
      current = 16'(c);
      tick();
      check("ring_state", 16'(alarm_state), (c < 10) ? 16'h1 : 16'h2);
      check("ring_led", 16'(SPDT_LED), (c < 10) ? 16'h0 : 16'h3FF);
    end

    exp_led = 10'h3FF;
    push_m  = 1'b1;
    exp_led = load_val(m_lfsr, exp_led);
    tick();
    push_m = 1'b0;
    check("press_state", 16'(alarm_state), 16'h4);
    check("press_led", 16'(SPDT_LED), 16'(exp_led));
    check("press_nz", 16'(SPDT_LED != 10'h0), 16'h1);
    check("press_n3ff", 16'(SPDT_LED != 10'h3FF), 16'h1);
    check("press_cnt", count_state, 16'h0);

    for (int i = 0; i < 3; i++) begin
      SPDTs    = exp_led;
      prev_led = exp_led;
      exp_led  = (i < 2) ? load_val(m_lfsr, exp_led) : 10'h0;
      tick();
      check("match_cnt", count_state, 16'(i + 1));
      check("match_led", 16'(SPDT_LED), 16'(exp_led));
      check("match_state", 16'(alarm_state), (i < 2) ? 16'h4 : 16'h0);
      check("match_fin", 16'(finish4), (i < 2) ? 16'h0 : 16'h1);
      if (i < 2) check("match_diff", 16'(SPDT_LED != prev_led), 16'h1);
    end

    SPDTs   = 10'h0;
    current = alarm;
    for (int i = 0; i < 4; i++) tick();
    check("done_state", 16'(alarm_state), 16'h0);
    check("done_cnt", count_state, 16'h3);
    check("done_fin", 16'(finish4), 16'h1);

    SPDT4 = 1'b0;
    tick();
    check("abort_fin", 16'(finish4), 16'h0);
    check("abort_cnt", count_state, 16'h0);
    SPDT4 = 1'b1;
    tick();
    check("rearm_state", 16'(alarm_state), 16'h1);
    tick();
    check("pre_eq_state", 16'(alarm_state), 16'h2);

    push_m  = 1'b1;
    exp_led = load_val(m_lfsr, 10'h3FF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_state", 16'(alarm_state), 16'h4);
      check("hold_led", 16'(SPDT_LED), 16'(exp_led));
    end
    push_m = 1'b0;

    for (int i = 0; i < 50; i++) tick();
    check("miss_cnt", count_state, 16'h0);
    check("miss_led", 16'(SPDT_LED), 16'(exp_led));
    check("miss_state", 16'(alarm_state), 16'h4);

    SPDTs    = exp_led;
    prev_led = exp_led;
    exp_led  = load_val(m_lfsr, exp_led);
    tick();
    check("late_cnt", count_state, 16'h1);
    check("late_led", 16'(SPDT_LED), 16'(exp_led));

    SPDT4 = 1'b0;
    tick();
    check("drop_state", 16'(alarm_state), 16'h0);
    check("drop_cnt", count_state, 16'h0);
    check("drop_led", 16'(SPDT_LED), 16'h0);
    check("drop_fin", 16'(finish4), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/service_4.md
Name: service_4

Overview:
- Alarm-clock "mission" service, selected by SPDT4. It arms itself, then rings when the current time equals the alarm time.
- After the user acknowledges with push_m, the user must copy a series of random 10-bit LED patterns onto the slide switches.
- After NUM_MISSIONS correct copies it raises finish4 to the top-level service controller.

Parameters:
- NUM_MISSIONS, 3: number of correct pattern matches required to finish.
- LFSR_SEED, 10'b1011001110: non-zero reset value of the pattern LFSR.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- SPDT4  input  1  service enable; low aborts the service and clears it.
- SPDTs  input  10  user slide switches, compared against SPDT_LED.
- push_m  input  1  acknowledge button, already debounced.
- current  input  16  current time value.
- alarm  input  16  alarm time value.
- alarm_state  output  3  FSM state, one-hot-like encoding: S0=000 idle, S1=001 armed, S2=010 ringing, S3=100 mission.
- count_state  output  16  number of matches completed (0..NUM_MISSIONS).
- SPDT_LED  output  10  LED pattern shown to the user.
- finish4  output  1  service complete, level.

Behaviour:
- All outputs are registered. resetn=0 at a clk edge gives: alarm_state=S0, count_state=0, SPDT_LED=0, finish4=0, LFSR=LFSR_SEED, push_m history=0.
- LFSR:
  - 10-bit Fibonacci LFSR, polynomial x^10+x^7+1.
  - Shifts left every clock regardless of state; feedback bit = lfsr[9]^lfsr[6] enters bit 0.
  - Never zero.
- Pattern load value:
  - Normally = lfsr.
  - If lfsr == SPDT_LED, load lfsr rotated left by 1.
  - If that also equals SPDT_LED (only possible for 10'h3FF), load 10'h155.
  - A newly loaded pattern therefore always differs from the previous SPDT_LED.
- Button edge: push_m is sampled into a register each clock. A press is push_m=1 while the previous sample was 0. A held button counts once.
- Abort: SPDT4=0 in any state → next cycle S0, count_state=0, SPDT_LED=0, finish4=0. This rule has priority over all transitions below.
- S0 (idle): SPDT_LED=0.
  - SPDT4=1 and finish4=0 → S1, count_state=0.
  - While finish4=1, stay in S0 (no re-arm until SPDT4 is dropped).
- S1 (armed): SPDT_LED=0.
  - current == alarm (exact 16-bit equality) → S2 next cycle.
  - No trigger if current skips past the alarm value.
  - If alarm already equals current when S1 is entered, the trigger fires on the next edge.
- S2 (ringing): SPDT_LED=10'h3FF (all LEDs lit).
  - A press → S3 and SPDT_LED = pattern load value.
  - Switch matches are ignored in S2.
- S3 (mission): evaluated each clock.
  - If SPDTs == SPDT_LED: count_state increments.
  - If the incremented value == NUM_MISSIONS: go to S0, finish4=1, SPDT_LED=0, count_state holds NUM_MISSIONS.
  - Otherwise stay in S3 and SPDT_LED = pattern load value on that same edge.
  - Mismatch: hold. Presses are ignored in S3.
  - Latency: one match is counted per clock at most. A switch value equal to the new pattern counts on the following edge.
- finish4 stays 1 while SPDT4=1. It clears only via abort or reset. count_state keeps its final value while finish4=1.
- Simultaneous events:
  - Reset beats abort; abort beats all other transitions.
  - In S1, a press alongside a time match is irrelevant; the only S1 transition is the time match.
- count_state is zero-extended to 16 bits; it never exceeds NUM_MISSIONS, so there is no wrap.

Test Plan:
1. Reset with resetn=0 for 2 cycles → alarm_state=000, count_state=0, SPDT_LED=0, finish4=0. Then SPDT4=1 → alarm_state=001 next edge, SPDT_LED=0.
2. Armed with alarm=10, step current 0..20 one per clock → alarm_state=010 on the edge after current==10, SPDT_LED=3FF, and it stays 010 while current continues to 20.
3. In S2, pulse push_m for 1 cycle → alarm_state=100, SPDT_LED non-zero and ≠3FF, count_state=0. Holding push_m for 5 cycles gives the same single transition.
4. In S3, drive SPDTs=SPDT_LED on 3 successive cycles →
   - count_state goes 1, 2, 3; SPDT_LED changes after each match, and every new value differs from the previous one.
   - After the third match: alarm_state=000, finish4=1, SPDT_LED=0.
   - A further copy of SPDTs has no effect.
5. In S3, drive SPDTs ≠ SPDT_LED for 50 cycles → count_state and SPDT_LED unchanged. Then drop SPDT4 → alarm_state=000, count_state=0, finish4=0.
6. With finish4=1 and SPDT4 held at 1, set current=alarm → state stays 000. Drop and raise SPDT4 → finish4=0 and alarm_state=001.
